// File: rtl/spike_queue_pkg.sv
// Shared constants and helpers for the multi-lane spike queue.
package spike_queue_pkg;

    // Width of the saturating rejected-push counter.
    localparam int unsigned DropCntBits = 16;
    localparam logic [DropCntBits-1:0] DropCntMax = 16'hFFFF;

    // Lane counts and ranks never exceed 4 lanes, so 3 bits always suffice.
    localparam int unsigned LaneCntBits = 3;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_queue_compact.sv
// Combinational lane compactor: ranks requesting lanes in ascending index
// order and accepts as many as there are free slots.
module spike_queue_compact
    import spike_queue_pkg::*;
#(
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned CNT_BITS = 5
) (
    input  logic [NUM_IN-1:0]                  enq,
    input  logic [CNT_BITS-1:0]                free,
    output logic [NUM_IN-1:0]                  accept,
    output logic [NUM_IN-1:0][LaneCntBits-1:0] rank,
    output logic [LaneCntBits-1:0]             accepted,
    output logic [LaneCntBits-1:0]             rejected
);

    // Prefix-count requesters; a lane is accepted while its rank is below free.
    always_comb begin
        int unsigned seen;
        int unsigned n_acc;
        int unsigned n_rej;
        seen   = 0;
        n_acc  = 0;
        n_rej  = 0;
        accept = '0;
        rank   = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            rank[k] = LaneCntBits'(seen);
            if (enq[k]) begin
                if (seen < 32'(free)) begin
                    accept[k] = 1'b1;
                    n_acc     = n_acc + 1;
                end else begin
                    n_rej = n_rej + 1;
                end
                seen = seen + 1;
            end
        end
        accepted = LaneCntBits'(n_acc);
        rejected = LaneCntBits'(n_rej);
    end

endmodule

// File: rtl/spike_queue.sv
// Multi-lane spike FIFO: up to NUM_IN pushes and one first-word-fall-through
// pop per cycle, with overflow accounting and an almost-full stall hint.
module spike_queue
    import spike_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TAG_BITS     = 8,
    parameter int unsigned NUM_IN       = 2,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         asyn_reset,
    input  logic [NUM_IN-1:0]            enq,
    input  logic [NUM_IN*TAG_BITS-1:0]   in_tags,
    input  logic                         deq,
    input  logic                         flush,
    output logic [TAG_BITS-1:0]          out_tag,
    output logic                         out_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [clog2(DEPTH):0]        count,
    output logic [DropCntBits-1:0]       drop_cnt
);

    localparam int unsigned PtrBits = clog2(DEPTH);
    localparam int unsigned CntBits = PtrBits + 1;

    logic [PtrBits-1:0]     head_q, head_d;
    logic [PtrBits-1:0]     tail_q, tail_d;
    logic [CntBits-1:0]     count_q, count_d;
    logic [DropCntBits-1:0] drop_q, drop_d;
    logic [TAG_BITS-1:0]    mem_q [DEPTH];

    logic                              is_empty;
    logic                              pop;
    logic [CntBits-1:0]                free;
    logic [NUM_IN-1:0]                 accept;
    logic [NUM_IN-1:0][LaneCntBits-1:0] rank;
    logic [LaneCntBits-1:0]            accepted;
    logic [LaneCntBits-1:0]            rejected;
    logic [DropCntBits:0]              drop_sum;
    logic [PtrBits-1:0]                waddr [NUM_IN];

    assign is_empty = (count_q == '0);
    assign pop      = deq && !is_empty;
    // A pop releases its slot to same-cycle pushes.
    assign free     = CntBits'(DEPTH) - count_q + CntBits'(pop);

    spike_queue_compact #(
        .NUM_IN   (NUM_IN),
        .CNT_BITS (CntBits)
    ) u_compact (
        .enq      (enq),
        .free     (free),
        .accept   (accept),
        .rank     (rank),
        .accepted (accepted),
        .rejected (rejected)
    );

    // Write address per lane: tail offset by the lane's rank, wrapping modulo DEPTH.
    always_comb begin
        for (int k = 0; k < int'(NUM_IN); k++) begin
            waddr[k] = tail_q + PtrBits'(rank[k]);
        end
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        drop_d   = drop_q;
        drop_sum = {1'b0, drop_q} + (DropCntBits + 1)'(rejected);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PtrBits'(pop);
            tail_d  = tail_q + PtrBits'(accepted);
            count_d = count_q + CntBits'(accepted) - CntBits'(pop);
            drop_d  = drop_sum[DropCntBits] ? DropCntMax : drop_sum[DropCntBits-1:0];
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Storage array is not reset; out_tag masking hides stale contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (!flush && accept[k]) begin
                mem_q[waddr[k]] <= in_tags[k*TAG_BITS +: TAG_BITS];
            end
        end
    end

    // Outputs derive from registered state only.
    always_comb begin
        empty       = is_empty;
        out_valid   = !is_empty;
        full        = (count_q == CntBits'(DEPTH));
        almost_full = (32'(count_q) >= AFULL_THRESH);
        count       = count_q;
        drop_cnt    = drop_q;
        out_tag     = is_empty ? '0 : mem_q[head_q];
    end

endmodule

// File: tb/tb_spike_queue.sv
// Self-checking bench for spike_queue with a queue-based reference model.
module tb_spike_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TAG_BITS = 8;
    localparam int unsigned NUM_IN   = 2;
    localparam int unsigned AFULL    = 2;

    logic                       clk;
    logic                       asyn_reset;
    logic [NUM_IN-1:0]          enq;
    logic [NUM_IN*TAG_BITS-1:0] in_tags;
    logic                       deq;
    logic                       flush;
    logic [TAG_BITS-1:0]        out_tag;
    logic                       out_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic [2:0]                 count;
    logic [15:0]                drop_cnt;

    int compared;
    int mismatched;

    // Reference model state.
    logic [7:0] mq[$];
    int unsigned m_drop;

    spike_queue #(
        .DEPTH        (DEPTH),
        .TAG_BITS     (TAG_BITS),
        .NUM_IN       (NUM_IN),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .enq         (enq),
        .in_tags     (in_tags),
        .deq         (deq),
        .flush       (flush),
        .out_tag     (out_tag),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_tag();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [2:0] m_count();
        return 3'(mq.size());
    endfunction

    // Apply one clock's worth of queue semantics to the model.
    task automatic model_step();
        int unsigned free_slots;
        if (flush) begin
            mq.delete();
            return;
        end
        if (deq && mq.size() > 0) void'(mq.pop_front());
        free_slots = DEPTH - mq.size();
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (enq[k]) begin
                if (free_slots > 0) begin
                    mq.push_back(in_tags[k*TAG_BITS +: TAG_BITS]);
                    free_slots--;
                end else if (m_drop < 32'hFFFF) begin
                    m_drop++;
                end
            end
        end
    endtask

    task automatic drive(input logic [1:0] e, input logic [7:0] t0, input logic [7:0] t1,
                         input logic d, input logic f);
        enq     = e;
        in_tags = {t1, t0};
        deq     = d;
        flush   = f;
    endtask

    // Advance one cycle: model, then sample 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        asyn_reset = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        mq.delete();
        m_drop = 0;
        repeat (2) tick();
        compared++;
        if (out_valid !== 1'b0 || out_tag !== 8'h00 || empty !== 1'b1) begin
            $display("FAIL reset_flags: valid=%b tag=%h empty=%b, want 0 00 1",
                     out_valid, out_tag, empty);
            mismatched++;
        end
        compared++;
        if (count !== 3'd0 || drop_cnt !== 16'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
            $display("FAIL reset_counts: count=%0d drop=%0d full=%b af=%b, want 0 0 0 0",
                     count, drop_cnt, full, almost_full);
            mismatched++;
        end
    endtask

    task automatic test_single_lane();
        logic [7:0] want [3];
        want[0] = 8'h11;
        want[1] = 8'h22;
        want[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, want[i], 8'hEE, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (out_tag !== want[i] || out_tag !== m_tag() || out_valid !== 1'b1) begin
                $display("FAIL single_order[%0d]: tag=%h valid=%b, want %h 1",
                         i, out_tag, out_valid, want[i]);
                mismatched++;
            end
            drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            tick();
        end
        compared++;
        if (empty !== 1'b1 || out_tag !== 8'h00) begin
            $display("FAIL single_empty: empty=%b tag=%h, want 1 00", empty, out_tag);
            mismatched++;
        end
    endtask

    task automatic test_dual_lane();
        drive(2'b11, 8'hA0, 8'hA1, 1'b0, 1'b0);
        tick();
        compared++;
        if (count !== m_count() || almost_full !== 1'b1 || out_tag !== 8'hA0) begin
            $display("FAIL dual_push: count=%0d af=%b tag=%h, want %0d 1 a0",
                     count, almost_full, out_tag, m_count());
            mismatched++;
        end
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        compared++;
        if (out_tag !== 8'hA1 || out_tag !== m_tag()) begin
            $display("FAIL dual_pop: tag=%h, want a1", out_tag);
            mismatched++;
        end
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        drive(2'b11, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        drive(2'b01, 8'h03, 8'h00, 1'b0, 1'b0);
        tick();
        compared++;
        if (count !== 3'd3) begin
            $display("FAIL ovf_fill: count=%0d, want 3", count);
            mismatched++;
        end
        drive(2'b11, 8'h04, 8'h05, 1'b0, 1'b0);
        tick();
        compared++;
        if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 16'(m_drop) || m_drop != 1) begin
            $display("FAIL ovf_drop: count=%0d full=%b drop=%0d, want 4 1 1",
                     count, full, drop_cnt);
            mismatched++;
        end
    endtask

    task automatic test_full_pop_push();
        drive(2'b11, 8'h06, 8'h07, 1'b1, 1'b0);
        tick();
        compared++;
        if (count !== 3'd4 || drop_cnt !== 16'(m_drop) || out_tag !== m_tag()) begin
            $display("FAIL full_pop_push: count=%0d drop=%0d tag=%h, want 4 %0d %h",
                     count, drop_cnt, out_tag, m_drop, m_tag());
            mismatched++;
        end
        // Drain and confirm the order 02 03 04 06.
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (out_tag !== m_tag()) begin
                $display("FAIL full_drain[%0d]: tag=%h, want %h", i, out_tag, m_tag());
                mismatched++;
            end
            drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_wrap_flush();
        logic [7:0] base;
        int unsigned drop_before;
        base = 8'h40;
        // Dual pushes with single pops walk the pointers across index 3 -> 0.
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, base, base + 8'h01, (mq.size() >= 2), 1'b0);
            base = base + 8'h02;
            tick();
            compared++;
            if (out_tag !== m_tag() || count !== m_count()) begin
                $display("FAIL wrap[%0d]: tag=%h count=%0d, want %h %0d",
                         i, out_tag, count, m_tag(), m_count());
                mismatched++;
            end
        end
        drop_before = m_drop;
        drive(2'b11, 8'hF0, 8'hF1, 1'b1, 1'b1);
        tick();
        compared++;
        if (count !== 3'd0 || empty !== 1'b1 || drop_cnt !== 16'(drop_before)) begin
            $display("FAIL flush: count=%0d empty=%b drop=%0d, want 0 1 %0d",
                     count, empty, drop_cnt, drop_before);
            mismatched++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            tick();
            compared++;
            if (out_tag !== m_tag() || count !== m_count() || drop_cnt !== 16'(m_drop) ||
                out_valid !== (mq.size() > 0) || full !== (mq.size() == DEPTH) ||
                almost_full !== (mq.size() >= AFULL)) begin
                $display("FAIL random[%0d]: tag=%h cnt=%0d drop=%0d v=%b f=%b af=%b, want %h %0d %0d",
                         i, out_tag, count, drop_cnt, out_valid, full, almost_full,
                         m_tag(), m_count(), m_drop);
                mismatched++;
            end
        end
    endtask

    task automatic test_async_reset();
        drive(2'b11, 8'h5A, 8'h5B, 1'b0, 1'b0);
        tick();
        drive(2'b11, 8'h5C, 8'h5D, 1'b0, 1'b0);
        tick();
        drive(2'b11, 8'h5E, 8'h5F, 1'b0, 1'b0);
        tick();
        // Assert reset between edges and sample before the next edge.
        #2;
        asyn_reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || out_tag !== 8'h00 || count !== 3'd0 ||
            full !== 1'b0 || almost_full !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL async_reset: v=%b e=%b tag=%h cnt=%0d f=%b af=%b drop=%0d",
                     out_valid, empty, out_tag, count, full, almost_full, drop_cnt);
            mismatched++;
        end
        #1;
        asyn_reset = 1'b0;
        mq.delete();
        m_drop = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        m_drop     = 0;
        test_reset();
        test_single_lane();
        test_dual_lane();
        test_overflow();
        test_full_pop_push();
        test_wrap_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spike_queue.md
# spike_queue

Parametrised multi-lane spike FIFO, the successor to the single-port fire FIFO. Each cycle up to NUM_IN neuron update lanes may each push one fired-neuron tag. The synapse dispatch stage drains one tag per cycle through a first-word-fall-through output. The buffer is a true circular buffer with head and tail pointers, overflow accounting and an almost-full back-pressure hint for the neuron scheduler.

## Interface
- DEPTH, 16, entry count; power of two, ≥ 2
- TAG_BITS, 8, neuron tag width
- NUM_IN, 2, enqueue lanes per cycle, 1..4
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value
- clk  in  1  clock, rising edge
- asyn_reset  in  1  asynchronous, active-high reset
- enq  in  NUM_IN  per-lane push request
- in_tags  in  NUM_IN*TAG_BITS  lane k tag in bits [k*TAG_BITS +: TAG_BITS]
- deq  in  1  pop request; ignored when empty
- flush  in  1  synchronous clear of queue contents
- out_tag  out  TAG_BITS  head entry; 0 when empty
- out_valid  out  1  equals !empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- count  out  clog2(DEPTH)+1  occupied entries
- drop_cnt  out  16  saturating count of rejected pushes

## Operation
- State: head, tail (clog2(DEPTH) bits, wrap modulo DEPTH), count, drop_cnt, and mem[DEPTH] (not reset).
- Pop: pop = deq && !empty. The head advances by 1 on pop.
- Free slots this cycle: free = DEPTH - count + pop. A pop frees its slot for same-cycle pushes, so a full queue with deq accepts one push.
- Lane acceptance: requesting lanes are ranked in ascending index order. The first min(#requests, free) are accepted.
  - The accepted lane of rank r writes mem[(tail + r) mod DEPTH].
  - tail advances by the accepted count.
- Rejected requests: drop_cnt += #rejected, saturating at 16'hFFFF.
- count_next = count + accepted - pop.
- flush: head, tail and count go to 0. Any enq or deq in the same cycle is ignored, and drop_cnt is not incremented. drop_cnt itself is retained.
- Reset: head = tail = count = 0 and drop_cnt = 0. Outputs after reset: empty=1, out_valid=0, full=0, almost_full=0 (0 when AFULL_THRESH>0), out_tag=0.
- Reset mid-operation discards all contents immediately (asynchronous). Stale mem data never appears because out_tag is masked to 0 while empty.

## Timing
- All state registers update on the rising clk edge. asyn_reset acts immediately, independent of clk.
- Outputs are combinational from registered state only; there is no path from enq, deq, flush or in_tags to any output.
- Enqueue-to-visibility latency: a tag pushed into an empty queue appears on out_tag with out_valid=1 in the next cycle.
- out_tag presents mem[head] continuously. On a pop the next entry is presented the following cycle.
- Simultaneous push and pop on a non-empty queue: count changes by accepted-1, and the FIFO order of all entries is preserved.
- Wrap-around: a multi-lane write may straddle index DEPTH-1 → 0. The ordering must remain correct across the wrap.
- full, almost_full and count reflect the registered count, so they lag the causing push by one cycle. Upstream treats almost_full as the stall hint.

## Structure
- Package spike_queue_pkg holds:
  - a clog2 function
  - the drop-counter width constant (16)
  - the saturation value
- Sub-module spike_queue_compact: a purely combinational lane compactor.
  - Inputs: enq and free.
  - Outputs: per-lane accept bits, per-lane rank offsets (prefix count), accepted total and rejected total.
- Top level holds the pointers, count, mem array and drop counter.

## Test plan
All scenarios use DEPTH=4, TAG_BITS=8, NUM_IN=2, AFULL_THRESH=2.
- Reset then idle: out_valid=0, out_tag=0, count=0, drop_cnt=0, empty=1.
- Single-lane ordering: push 8'h11, 8'h22, 8'h33 on lane 0 in consecutive cycles, then deq ×3. out_tag reads 11, 22, 33, then empty=1.
- Dual-lane push: enq=2'b11 with lane0=8'hA0, lane1=8'hA1. Next cycle count=2, almost_full=1, out_tag=A0; after one pop, out_tag=A1.
- Overflow: fill to count=3, then enq=2'b11 with no deq. Lane 0 is accepted and lane 1 dropped; count=4, full=1, drop_cnt=1.
- Full with simultaneous pop and dual push: at count=4, deq=1 and enq=2'b11. One push is accepted (lane 0); count stays 4 and drop_cnt increments by 1.
- Wrap and flush:
  - Cycle pointers through index 3→0 using dual pushes and pops, and check FIFO order across the wrap.
  - Assert flush together with enq=2'b11: count=0 and empty=1 next cycle, with drop_cnt unchanged.
  - Assert asyn_reset mid-stream: all outputs return to reset values without a clock edge.
